// File: rtl/dnn_seq_array.sv
// ============================================================================
// Module   : dnn_seq_array
// Purpose  : Time-multiplexed fully connected DNN forward pass on one signed
//            MAC, with a writable weight/bias register file and valid/ready I/O.
//            Optional macro DNN_SAT_EN saturates the activation result.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dnn_seq_array #(
    parameter int N_IN   = 2,
    parameter int N_OUT  = 2,
    parameter int N_HL   = 1,
    parameter int N_HL_P = 3,
    parameter int WIDTH  = 32,
    parameter int FRAC   = 24,
    localparam int W_TOT = N_HL_P*(N_IN+1) + (N_HL-1)*N_HL_P*(N_HL_P+1) + N_OUT*(N_HL_P+1),
    localparam int AW    = (W_TOT > 1) ? $clog2(W_TOT) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr,
    input  logic [AW-1:0]            w_addr,
    input  logic [WIDTH-1:0]         w_data,
    input  logic                     i_valid,
    output logic                     i_ready,
    input  logic [N_IN*WIDTH-1:0]    i,
    output logic                     o_valid,
    input  logic                     o_ready,
    output logic [N_OUT*WIDTH-1:0]   o,
    output logic                     busy
);

    localparam int NMAX  = (N_IN > N_HL_P) ? N_IN : N_HL_P;
    localparam int NBUF  = (NMAX > N_OUT) ? NMAX : N_OUT;
    localparam int BW    = (NBUF > 1) ? $clog2(NBUF) : 1;
    localparam int LW    = $clog2(N_HL + 1);
    localparam int AW2   = 2 * WIDTH;
    localparam logic [AW:0] W_TOT_C = (AW+1)'(W_TOT);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_MAC  = 3'd2,
        S_ACT  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t                   state_q, state_d;
    logic [WIDTH-1:0]         w_mem_q [W_TOT];
    logic [WIDTH-1:0]         a_q     [NBUF];
    logic [WIDTH-1:0]         b_q     [NBUF];
    logic [WIDTH-1:0]         b_d     [NBUF];
    logic signed [AW2-1:0]    acc_q;
    logic [BW-1:0]            k_q;
    logic [BW-1:0]            p_q;
    logic [LW-1:0]            layer_q;
    logic [AW-1:0]            wptr_q;
    logic [N_OUT*WIDTH-1:0]   o_q;

    logic                     w_last_layer;
    logic [BW-1:0]            w_fanin_m1;
    logic [BW-1:0]            w_nperc_m1;
    logic [AW-1:0]            w_stride;
    logic [AW-1:0]            w_raddr;
    logic [WIDTH-1:0]         w_wgt;
    logic [WIDTH-1:0]         w_a;
    logic [AW2-1:0]           w_prod;
    logic [AW2-1:0]           w_bias_ext;
    logic signed [AW2-1:0]    w_sh;
    logic [WIDTH-1:0]         w_r;
    logic [WIDTH-1:0]         w_act;
    logic                     w_wr_en;
    logic                     w_last_perc;

    assign w_last_layer = (layer_q == LW'(N_HL));
    assign w_fanin_m1   = (layer_q == '0) ? BW'(N_IN - 1) : BW'(N_HL_P - 1);
    assign w_nperc_m1   = w_last_layer ? BW'(N_OUT - 1) : BW'(N_HL_P - 1);
    assign w_stride     = (layer_q == '0) ? AW'(N_IN + 1) : AW'(N_HL_P + 1);
    assign w_last_perc  = (p_q == w_nperc_m1);

    // Bias sits at offset 0 of the perceptron block, weight k at offset k+1.
    assign w_raddr    = (state_q == S_LOAD) ? wptr_q : (wptr_q + AW'(1) + AW'(k_q));
    assign w_wgt      = w_mem_q[w_raddr];
    assign w_a        = a_q[k_q];
    assign w_prod     = {{WIDTH{w_a[WIDTH-1]}}, w_a} * {{WIDTH{w_wgt[WIDTH-1]}}, w_wgt};
    assign w_bias_ext = {{WIDTH{w_wgt[WIDTH-1]}}, w_wgt} << FRAC;
    assign w_sh       = acc_q >>> FRAC;

`ifdef DNN_SAT_EN
    logic w_ovf;
    assign w_ovf = ~((&w_sh[AW2-1:WIDTH-1]) | ~(|w_sh[AW2-1:WIDTH-1]));
    assign w_r   = w_ovf ? (w_sh[AW2-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}})
                         : w_sh[WIDTH-1:0];
`else
    logic w_unused_hi;
    assign w_unused_hi = ^w_sh[AW2-1:WIDTH];
    assign w_r         = w_sh[WIDTH-1:0];
`endif

    // Hidden layers are ReLU, the output layer is linear.
    assign w_act   = (!w_last_layer && w_r[WIDTH-1]) ? '0 : w_r;
    assign w_wr_en = wr && (state_q == S_IDLE) && ({1'b0, w_addr} < W_TOT_C);

    always_comb begin
        for (int j = 0; j < NBUF; j++) begin
            b_d[j] = b_q[j];
        end
        b_d[p_q] = w_act;
    end

    always_comb begin
        state_d = state_q;
        i_ready = 1'b0;
        o_valid = 1'b0;
        busy    = (state_q != S_IDLE);
        case (state_q)
            S_IDLE: begin
                i_ready = !rst;
                if (i_valid) state_d = S_LOAD;
            end
            S_LOAD: state_d = S_MAC;
            S_MAC:  if (k_q == w_fanin_m1) state_d = S_ACT;
            S_ACT:  state_d = (w_last_perc && w_last_layer) ? S_DONE : S_LOAD;
            S_DONE: begin
                o_valid = 1'b1;
                if (o_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            for (int j = 0; j < W_TOT; j++) w_mem_q[j] <= '0;
            for (int j = 0; j < NBUF; j++) begin
                a_q[j] <= '0;
                b_q[j] <= '0;
            end
            acc_q   <= '0;
            k_q     <= '0;
            p_q     <= '0;
            layer_q <= '0;
            wptr_q  <= '0;
            o_q     <= '0;
        end else begin
            state_q <= state_d;
            if (w_wr_en) w_mem_q[w_addr] <= w_data;
            case (state_q)
                S_IDLE: begin
                    if (i_valid) begin
                        for (int j = 0; j < N_IN; j++) a_q[j] <= i[j*WIDTH +: WIDTH];
                        for (int j = N_IN; j < NBUF; j++) a_q[j] <= '0;
                        layer_q <= '0;
                        p_q     <= '0;
                        wptr_q  <= '0;
                    end
                end
                S_LOAD: begin
                    acc_q <= w_bias_ext;
                    k_q   <= '0;
                end
                S_MAC: begin
                    acc_q <= acc_q + w_prod;
                    k_q   <= k_q + BW'(1);
                end
                S_ACT: begin
                    b_q    <= b_d;
                    wptr_q <= wptr_q + w_stride;
                    if (!w_last_perc) begin
                        p_q <= p_q + BW'(1);
                    end else if (w_last_layer) begin
                        for (int j = 0; j < N_OUT; j++) o_q[j*WIDTH +: WIDTH] <= b_d[j];
                    end else begin
                        a_q     <= b_d;
                        layer_q <= layer_q + LW'(1);
                        p_q     <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o = o_q;

endmodule

`default_nettype wire

// File: tb/tb_dnn_seq_array.sv
// ============================================================================
// Module   : tb_dnn_seq_array
// Purpose  : Self-checking bench for dnn_seq_array against a forward-pass model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dnn_seq_array;

    localparam int W_TOT = 17;
    localparam logic [31:0] ONE = 32'h0100_0000;

    logic        clk = 1'b0;
    logic        rst, wr, i_valid, i_ready, o_valid, o_ready, busy;
    logic [4:0]  w_addr;
    logic [31:0] w_data;
    logic [63:0] i, o;

    int n_checks = 0;
    int n_fail   = 0;
    logic signed [31:0] wm [W_TOT];

    dnn_seq_array dut (
        .clk(clk), .rst(rst), .wr(wr), .w_addr(w_addr), .w_data(w_data),
        .i_valid(i_valid), .i_ready(i_ready), .i(i),
        .o_valid(o_valid), .o_ready(o_ready), .o(o), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] act(input longint acc, input bit relu);
        longint s;
        logic [31:0] r;
        s = acc >>> 24;
`ifdef DNN_SAT_EN
        if (s > 64'sd2147483647)       r = 32'h7FFF_FFFF;
        else if (s < -64'sd2147483648) r = 32'h8000_0000;
        else                           r = s[31:0];
`else
        r = s[31:0];
`endif
        if (relu && r[31]) r = '0;
        return r;
    endfunction

    // Network: 2 inputs -> 3 ReLU hidden -> 2 linear outputs.
    function automatic logic [63:0] model(input logic signed [31:0] x0, input logic signed [31:0] x1);
        logic signed [31:0] h [3];
        logic [63:0] res;
        longint acc;
        int base;
        for (int p = 0; p < 3; p++) begin
            acc = longint'(wm[p*3]) <<< 24;
            acc += longint'(x0) * longint'(wm[p*3+1]);
            acc += longint'(x1) * longint'(wm[p*3+2]);
            h[p] = act(acc, 1'b1);
        end
        for (int q = 0; q < 2; q++) begin
            base = 9 + q*4;
            acc = longint'(wm[base]) <<< 24;
            for (int k = 0; k < 3; k++) acc += longint'(h[k]) * longint'(wm[base+1+k]);
            res[q*32 +: 32] = act(acc, 1'b0);
        end
        return res;
    endfunction

    task automatic write_w(input int a, input logic [31:0] d);
        wr = 1'b1; w_addr = a[4:0]; w_data = d;
        @(negedge clk);
        wr = 1'b0;
        if (a < W_TOT) wm[a] = d;
    endtask

    task automatic write_layout(input logic [31:0] hw, input logic [31:0] hb,
                                input logic [31:0] ow, input logic [31:0] ob);
        for (int a = 0; a < W_TOT; a++) begin
            if (a < 9) write_w(a, (a % 3 == 0) ? hb : hw);
            else       write_w(a, ((a - 9) % 4 == 0) ? ob : ow);
        end
    endtask

    task automatic write_random();
        for (int a = 0; a < W_TOT; a++) write_w(a, $urandom);
    endtask

    task automatic run_pass(input logic [31:0] x0, input logic [31:0] x1,
                            input bit same_wr, input bit mac_wr, input int wa,
                            input logic [31:0] wd, output logic [63:0] got, output int lat);
        i = {x1, x0}; i_valid = 1'b1; o_ready = 1'b1;
        if (same_wr) begin
            wr = 1'b1; w_addr = wa[4:0]; w_data = wd; wm[wa] = wd;
        end
        @(negedge clk);
        i_valid = 1'b0; wr = 1'b0;
        lat = 0;
        while (!o_valid && lat < 200) begin
            if (mac_wr && lat == 1) begin
                wr = 1'b1; w_addr = wa[4:0]; w_data = wd;
            end else begin
                wr = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        wr = 1'b0;
        got = o;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; wr = 1'b0; w_addr = '0; w_data = '0; i_valid = 1'b0; o_ready = 1'b0; i = '0;
        @(negedge clk); @(negedge clk);
        n_checks++; if (i_ready !== 1'b0) begin n_fail++; $display("FAIL reset_i_ready: got %b expected 0", i_ready); end
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_o_valid: got %b expected 0", o_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (o !== 64'h0) begin n_fail++; $display("FAIL reset_o: got %h expected 0", o); end
        rst = 1'b0;
        for (int a = 0; a < W_TOT; a++) wm[a] = '0;
        @(negedge clk);
        n_checks++; if (i_ready !== 1'b1) begin n_fail++; $display("FAIL idle_i_ready: got %b expected 1", i_ready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_known_values();
        logic [63:0] got;
        int lat;
        write_layout(ONE, 32'h0, ONE, 32'h0);
        run_pass(ONE, 2*ONE, 0, 0, 0, 0, got, lat);
        n_checks++; if (got !== {2{32'h0900_0000}}) begin n_fail++; $display("FAIL ones_o: got %h expected %h", got, {2{32'h0900_0000}}); end
        n_checks++; if (lat !== 22) begin n_fail++; $display("FAIL ones_latency: got %0d expected 22", lat); end
        write_layout(32'hFF00_0000, 32'h0, ONE, 32'h0080_0000);
        run_pass(ONE, ONE, 0, 0, 0, 0, got, lat);
        n_checks++; if (got !== {2{32'h0080_0000}}) begin n_fail++; $display("FAIL relu_o: got %h expected %h", got, {2{32'h0080_0000}}); end
    endtask

    task automatic test_backpressure();
        logic [63:0] o0, exp;
        int lat;
        write_random();
        exp = model(ONE, 32'hFF80_0000);
        i = {32'hFF80_0000, ONE}; i_valid = 1'b1; o_ready = 1'b0;
        @(negedge clk);
        i_valid = 1'b0;
        lat = 0;
        while (!o_valid && lat < 200) begin @(negedge clk); lat++; end
        o0 = o;
        n_checks++; if (o0 !== exp) begin n_fail++; $display("FAIL bp_o: got %h expected %h", o0, exp); end
        i_valid = 1'b1; i = 64'h0300_0000_0300_0000;
        for (int c = 0; c < 5; c++) begin
            n_checks++; if (o_valid !== 1'b1 || o !== o0) begin n_fail++; $display("FAIL bp_hold: o_valid %b o %h expected 1 %h", o_valid, o, o0); end
            n_checks++; if (i_ready !== 1'b0) begin n_fail++; $display("FAIL bp_i_ready: got %b expected 0", i_ready); end
            @(negedge clk);
        end
        i_valid = 1'b0; o_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (o_valid !== 1'b0 || busy !== 1'b0 || i_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_release: o_valid %b busy %b i_ready %b expected 0 0 1", o_valid, busy, i_ready);
        end
        @(negedge clk);
        n_checks++; if (busy !== 1'b0 || o !== o0) begin n_fail++; $display("FAIL bp_after: busy %b o %h expected 0 %h", busy, o, o0); end
    endtask

    task automatic test_overflow();
        logic [63:0] got, exp;
        int lat;
        write_layout(32'h6400_0000, 32'h6400_0000, 32'h6400_0000, 32'h6400_0000);
        exp = model(32'h6400_0000, 32'h6400_0000);
        run_pass(32'h6400_0000, 32'h6400_0000, 0, 0, 0, 0, got, lat);
        n_checks++; if (got !== exp) begin n_fail++; $display("FAIL overflow_model: got %h expected %h", got, exp); end
`ifdef DNN_SAT_EN
        n_checks++; if (got !== {2{32'h7FFF_FFFF}}) begin n_fail++; $display("FAIL overflow_sat: got %h expected %h", got, {2{32'h7FFF_FFFF}}); end
`endif
    endtask

    task automatic test_dropped_writes();
        logic [63:0] got, exp;
        logic [31:0] x0, x1;
        int lat;
        write_random();
        x0 = $urandom; x1 = $urandom;
        exp = model(x0, x1);
        run_pass(x0, x1, 0, 1, 0, $urandom, got, lat);
        n_checks++; if (got !== exp) begin n_fail++; $display("FAIL drop_mac_wr: got %h expected %h", got, exp); end
        write_w(W_TOT, $urandom);
        run_pass(x0, x1, 0, 0, 0, 0, got, lat);
        n_checks++; if (got !== exp) begin n_fail++; $display("FAIL drop_oob_wr: got %h expected %h", got, exp); end
    endtask

    task automatic test_same_cycle_wr();
        logic [63:0] got, exp;
        logic [31:0] x0, x1, nw;
        int lat;
        x0 = $urandom; x1 = $urandom; nw = $urandom;
        wm[0] = nw;
        exp = model(x0, x1);
        run_pass(x0, x1, 1, 0, 0, nw, got, lat);
        n_checks++; if (got !== exp) begin n_fail++; $display("FAIL same_cycle_wr: got %h expected %h", got, exp); end
    endtask

    task automatic test_random();
        logic [63:0] got, exp;
        logic [31:0] x0, x1;
        int lat;
        for (int n = 0; n < 6; n++) begin
            write_random();
            x0 = $urandom; x1 = $urandom;
            exp = model(x0, x1);
            run_pass(x0, x1, 0, 0, 0, 0, got, lat);
            n_checks++; if (got !== exp) begin n_fail++; $display("FAIL random_%0d: got %h expected %h", n, got, exp); end
            n_checks++; if (lat !== 22) begin n_fail++; $display("FAIL random_lat_%0d: got %0d expected 22", n, lat); end
        end
    endtask

    task automatic test_rst_abort();
        logic [63:0] got;
        int lat;
        write_layout(ONE, ONE, ONE, ONE);
        i = {ONE, ONE}; i_valid = 1'b1; o_ready = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        repeat (10) @(negedge clk);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy_before: got %b expected 1", busy); end
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (o_valid !== 1'b0 || o !== 64'h0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL abort_state: o_valid %b o %h busy %b expected 0 0 0", o_valid, o, busy);
        end
        rst = 1'b0;
        for (int a = 0; a < W_TOT; a++) wm[a] = '0;
        @(negedge clk);
        run_pass($urandom, $urandom, 0, 0, 0, 0, got, lat);
        n_checks++; if (got !== 64'h0) begin n_fail++; $display("FAIL abort_cleared: got %h expected 0", got); end
        n_checks++; if (lat !== 22) begin n_fail++; $display("FAIL abort_latency: got %0d expected 22", lat); end
    endtask

    initial begin
        test_reset();
        test_known_values();
        test_backpressure();
        test_overflow();
        test_dropped_writes();
        test_same_cycle_wr();
        test_random();
        test_rst_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
